tone_decoder: RTL
=================

// Module: tone_decoder
// PURPOSE
//  Receive side of the buzzer tone path: measures the period of a square-wave tone
//  input and classifies it as one of the seven scale notes DO..SI (50 MHz sys_clk).
//  Reports a stable note code once several consecutive periods agree, and reports
//  silence after a timeout. Used to self-check the beep generator or decode an external tone.
// PARAMETERS
//  DO..SI     18'd190_839,170_067,151_515,143_266,127_551,113_636,101_214  nominal period-1 per note, in clocks
//  TOL        18'd2_000    accepted +/- deviation of measured value from a nominal
//  MATCH_CNT  3'd4         consecutive matching periods required to lock
//  TIMEOUT    19'd400_000  clocks without rising edge => silence
// PORTS
//  sys_clk      in   1   system clock, 50 MHz
//  sys_rst_n    in   1   asynchronous, active-low reset
//  tone_in      in   1   asynchronous square-wave tone input
//  note_code    out  3   0=none, 1=DO,2=RE,3=MI,4=FA,5=SO,6=LA,7=SI
//  note_valid   out  1   high while locked on note_code
//  note_change  out  1   one-cycle pulse on every entry into LOCKED
//  period_out   out  18  last measured value (clocks between rising edges minus 1), saturating
// BEHAVIOUR
//  Reset: note_code=0, note_valid=0, note_change=0, period_out=0, state IDLE, armed=0.
//  Input: 2-flop synchronizer, then edge flop; rise = sync & ~sync_d. 3-cycle input latency.
//  Period counter per_cnt (19b): clears to 0 on rise, else +1, saturates at TIMEOUT.
//  On rise with armed=1: measured m = per_cnt; period_out <= min(m,18'h3FFFF).
//   First rise after reset/timeout only sets armed=1 (no measurement).
//  Classify: m matches note k iff NOTE_k-TOL <= m <= NOTE_k+TOL; ranges are disjoint
//   with defaults; none => code 0. Compare in 19 bits, no wrap.
//  FSM (transitions only on a measured rise, except timeout):
//   IDLE:    match k -> ACQUIRE, cand=k, mcnt=1; no match -> stay.
//   ACQUIRE: match cand -> mcnt+1; if mcnt+1==MATCH_CNT -> LOCKED.
//            match other j -> cand=j, mcnt=1. no match -> IDLE.
//   LOCKED:  match cand -> stay. any other -> ACQUIRE (cand=j,mcnt=1) or IDLE if none;
//            note_valid, note_code drop to 0 the cycle after that rise.
//   Any state: per_cnt reaches TIMEOUT -> IDLE, armed=0, outputs cleared next cycle.
//  Outputs registered: note_valid=1, note_code=cand, note_change=1 for exactly one cycle,
//   all on the clock after the rise completing the MATCH_CNT-th match.
//  MATCH_CNT=1 locks on first measured period. Rise and timeout same cycle: rise wins.
//  Single short/odd period (generator note switch) drops lock; relock after MATCH_CNT periods.
//  Reset mid-operation: all state/outputs clear asynchronously; full re-acquire needed.
//  Duty cycle of tone_in is irrelevant; only rising edges are used.
// STRUCTURE
//  Shared package beep_pkg: note period constants DO..SI (shared with beep generator),
//   note code constants NOTE_NONE..NOTE_SI, FSM state enum {IDLE,ACQUIRE,LOCKED}.
//  Sub-module tone_period_meter: synchronizer, edge detect, per_cnt, armed flag,
//   outputs meas_valid/meas/timeout. Classifier + FSM + output regs in tone_decoder.
// TESTING
//  1 Reset, tone_in idle -> all outputs 0; after TIMEOUT still 0, no note_change.
//  2 Square wave period 190_840 clocks (m=190_839) -> lock on rise completing 4th match
//    (5th rise); note_code=1, note_valid=1, one note_change pulse; period_out=190_839.
//  3 Drive beep generator pattern DO..SI 500 ms each -> codes 1..7 in order, each locked
//    <=6 periods after switch, note_valid low between notes, 7 note_change pulses per loop.
//  4 Tolerance edges: m=101_214+2_000 -> locks SI; m=103_215 -> never valid; m=160_000 -> code 0.
//  5 Locked on MI, stop toggling -> note_valid=0, note_code=0 at TIMEOUT after last rise;
//    restart tone -> first rise unmeasured, lock after 4 further matches.
//  6 Assert sys_rst_n low mid-lock for 3 clocks -> outputs 0 immediately; after release
//    requires arming rise + 4 matches before note_valid.

Source files
------------

// File: rtl/beep_pkg.sv
// Constants and types shared by the buzzer tone generator and the tone decoder.
// Note periods are stored as (clocks per period - 1) at 50 MHz.
package beep_pkg;

  localparam logic [17:0] DO = 18'd190_839;
  localparam logic [17:0] RE = 18'd170_067;
  localparam logic [17:0] MI = 18'd151_515;
  localparam logic [17:0] FA = 18'd143_266;
  localparam logic [17:0] SO = 18'd127_551;
  localparam logic [17:0] LA = 18'd113_636;
  localparam logic [17:0] SI = 18'd101_214;

  localparam logic [17:0] TOL_DEF       = 18'd2_000;
  localparam logic [2:0]  MATCH_CNT_DEF = 3'd4;
  localparam logic [18:0] TIMEOUT_DEF   = 19'd400_000;

  localparam logic [2:0] NOTE_NONE = 3'd0;
  localparam logic [2:0] NOTE_DO   = 3'd1;
  localparam logic [2:0] NOTE_RE   = 3'd2;
  localparam logic [2:0] NOTE_MI   = 3'd3;
  localparam logic [2:0] NOTE_FA   = 3'd4;
  localparam logic [2:0] NOTE_SO   = 3'd5;
  localparam logic [2:0] NOTE_LA   = 3'd6;
  localparam logic [2:0] NOTE_SI   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  // Widened to 20 bits so neither nom-tol nor nom+tol can wrap.
  function automatic logic in_band(input logic [18:0] m, input logic [17:0] nom,
                                   input logic [17:0] tol);
    logic [19:0] m_w;
    logic [19:0] nom_w;
    logic [19:0] tol_w;
    m_w   = {1'b0, m};
    nom_w = {2'b00, nom};
    tol_w = {2'b00, tol};
    return ((m_w + tol_w) >= nom_w) && (m_w <= (nom_w + tol_w));
  endfunction

endpackage

// File: rtl/tone_period_meter.sv
// Synchronises the tone input, detects rising edges and measures the clocks
// between them; flags silence when no edge arrives for TIMEOUT clocks.
module tone_period_meter
  import beep_pkg::*;
#(
  parameter logic [18:0] TIMEOUT = TIMEOUT_DEF
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        tone_in,
  output logic        meas_valid,
  output logic [18:0] meas,
  output logic        timeout
);

  logic        sync1_q;
  logic        sync2_q;
  logic        edge_q;
  logic        rise;
  logic [18:0] per_cnt_q;
  logic [18:0] per_cnt_d;
  logic        armed_q;
  logic        armed_d;

  assign rise       = sync2_q & ~edge_q;
  assign meas_valid = rise & armed_q;
  assign meas       = per_cnt_q;
  // A rise landing on the saturation cycle is still measured.
  assign timeout    = ~rise & (per_cnt_q == TIMEOUT);

  always_comb begin
    per_cnt_d = per_cnt_q;
    armed_d   = armed_q;
    if (rise) begin
      per_cnt_d = '0;
      armed_d   = 1'b1;
    end else begin
      if (per_cnt_q < TIMEOUT) begin
        per_cnt_d = per_cnt_q + 19'd1;
      end
      if (timeout) begin
        armed_d = 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      edge_q    <= 1'b0;
      per_cnt_q <= '0;
      armed_q   <= 1'b0;
    end else begin
      sync1_q   <= tone_in;
      sync2_q   <= sync1_q;
      edge_q    <= sync2_q;
      per_cnt_q <= per_cnt_d;
      armed_q   <= armed_d;
    end
  end

endmodule

// File: rtl/tone_decoder.sv
// Classifies measured tone periods into scale notes and locks onto a note once
// MATCH_CNT consecutive periods agree.
module tone_decoder
  import beep_pkg::*;
#(
  parameter logic [17:0] PER_DO    = DO,
  parameter logic [17:0] PER_RE    = RE,
  parameter logic [17:0] PER_MI    = MI,
  parameter logic [17:0] PER_FA    = FA,
  parameter logic [17:0] PER_SO    = SO,
  parameter logic [17:0] PER_LA    = LA,
  parameter logic [17:0] PER_SI    = SI,
  parameter logic [17:0] TOL       = TOL_DEF,
  parameter logic [2:0]  MATCH_CNT = MATCH_CNT_DEF,
  parameter logic [18:0] TIMEOUT   = TIMEOUT_DEF
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        tone_in,
  output logic [2:0]  note_code,
  output logic        note_valid,
  output logic        note_change,
  output logic [17:0] period_out
);

  localparam logic [17:0] NOMINAL [7] = '{PER_DO, PER_RE, PER_MI, PER_FA,
                                          PER_SO, PER_LA, PER_SI};

  logic        meas_valid;
  logic        timeout;
  logic [18:0] meas;
  logic [6:0]  hit;
  logic [2:0]  cls;

  state_e      state_q, state_d;
  logic [2:0]  cand_q, cand_d;
  logic [2:0]  mcnt_q, mcnt_d;
  logic [3:0]  mcnt_inc;
  logic [2:0]  code_q, code_d;
  logic        valid_q, valid_d;
  logic        change_q, change_d;
  logic [17:0] period_q, period_d;

  tone_period_meter #(
    .TIMEOUT(TIMEOUT)
  ) u_meter (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .tone_in   (tone_in),
    .meas_valid(meas_valid),
    .meas      (meas),
    .timeout   (timeout)
  );

  for (genvar gi = 0; gi < 7; gi++) begin : g_band
    assign hit[gi] = in_band(meas, NOMINAL[gi], TOL);
  end

  always_comb begin
    cls = NOTE_NONE;
    for (int k = 6; k >= 0; k--) begin
      if (hit[k]) cls = 3'(k + 1);
    end
  end

  assign mcnt_inc = {1'b0, mcnt_q} + 4'd1;

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    mcnt_d   = mcnt_q;
    code_d   = code_q;
    valid_d  = valid_q;
    change_d = 1'b0;
    period_d = period_q;
    if (meas_valid) begin
      period_d = (meas > 19'h3FFFF) ? 18'h3FFFF : meas[17:0];
      // Any measured period drops the outputs unless it keeps or makes a lock.
      valid_d  = 1'b0;
      code_d   = NOTE_NONE;
      if (cls == NOTE_NONE) begin
        state_d = ST_IDLE;
      end else if (state_q == ST_LOCKED && cls == cand_q) begin
        valid_d = 1'b1;
        code_d  = cand_q;
      end else if (state_q == ST_ACQUIRE && cls == cand_q) begin
        mcnt_d = mcnt_inc[2:0];
        if (mcnt_inc == {1'b0, MATCH_CNT}) begin
          state_d  = ST_LOCKED;
          valid_d  = 1'b1;
          code_d   = cls;
          change_d = 1'b1;
        end
      end else begin
        cand_d  = cls;
        mcnt_d  = 3'd1;
        state_d = ST_ACQUIRE;
        if (MATCH_CNT <= 3'd1) begin
          state_d  = ST_LOCKED;
          valid_d  = 1'b1;
          code_d   = cls;
          change_d = 1'b1;
        end
      end
    end else if (timeout) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      code_d  = NOTE_NONE;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      cand_q   <= NOTE_NONE;
      mcnt_q   <= '0;
      code_q   <= NOTE_NONE;
      valid_q  <= 1'b0;
      change_q <= 1'b0;
      period_q <= '0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      mcnt_q   <= mcnt_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      change_q <= change_d;
      period_q <= period_d;
    end
  end

  assign note_code   = code_q;
  assign note_valid  = valid_q;
  assign note_change = change_q;
  assign period_out  = period_q;

endmodule
